wb_select_stage: RTL and testbench

// Registered, handshaked writeback selector for the pipelined MIPS datapath. It

---
 rtl/wb_select_stage_if.sv | 30 +++
 rtl/wb_select_stage.sv | 59 +++++
 tb/tb_wb_select_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/wb_select_stage_if.sv
// wb_select_stage_if: request/writeback bundle between MEM and the register-file write port
interface wb_select_stage_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2,
    parameter int AW    = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SELW-1:0]       data_sel;
    logic [1:0]            dst_sel;
    logic [AW-1:0]         rd_addr;
    logic [AW-1:0]         rt_addr;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  slow_valid;
    logic [WIDTH-1:0]      slow_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [WIDTH-1:0]      wr_data;
    modport master (
        output in_valid, data_sel, dst_sel, rd_addr, rt_addr, src_data, slow_valid, slow_data, out_ready,
        input  in_ready, out_valid, wr_en, wr_addr, wr_data
    );
    modport slave (
        input  in_valid, data_sel, dst_sel, rd_addr, rt_addr, src_data, slow_valid, slow_data, out_ready,
        output in_ready, out_valid, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/wb_select_stage.sv
// wb_select_stage: registered writeback source/destination selector with slow-source wait state
module wb_select_stage #(
    parameter int WIDTH    = 32,
    parameter int NSRC     = 4,
    parameter int SELW     = 2,
    parameter int AW       = 5,
    parameter int SLOW_IDX = 1,
    parameter int RA_ADDR  = 31
) (
    input logic clk,
    input logic reset,
    input logic flush,
    wb_select_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;
    state_t           state;
    logic             accept;
    logic             is_slow;
    logic [AW-1:0]    dst;
    logic [WIDTH-1:0] fast;
    always_comb begin
        bus.in_ready = !flush && (state == IDLE || (state == FULL && bus.out_ready));
        accept       = bus.in_valid && bus.in_ready;
        is_slow      = bus.data_sel == SELW'(SLOW_IDX);
        dst          = bus.dst_sel == 2'd0 ? bus.rd_addr :
                       bus.dst_sel == 2'd1 ? bus.rt_addr :
                       bus.dst_sel == 2'd2 ? AW'(RA_ADDR) : '0;
        fast         = int'(bus.data_sel) < NSRC ? bus.src_data[int'(bus.data_sel)*WIDTH +: WIDTH] : '0;
        bus.wr_en    = !flush && bus.out_valid && bus.out_ready && bus.wr_addr != '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
        end else if (flush) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.wr_addr <= dst;
            if (is_slow && !bus.slow_valid) begin
                state         <= WAIT;
                bus.out_valid <= 1'b0;
            end else begin
                state         <= FULL;
                bus.out_valid <= 1'b1;
                bus.wr_data   <= is_slow ? bus.slow_data : fast;
            end
        end else if (state == WAIT && bus.slow_valid) begin
            state         <= FULL;
            bus.out_valid <= 1'b1;
            bus.wr_data   <= bus.slow_data;
        end else if (state == FULL && bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_select_stage.sv
// tb_wb_select_stage: directed checks of wb_select_stage with immediate assertions
module tb_wb_select_stage;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   errors = 0;
    int   checks = 0;
    wb_select_stage_if #(.WIDTH(32), .NSRC(4), .SELW(2), .AW(5)) bus ();
    wb_select_stage #(.WIDTH(32), .NSRC(4), .SELW(2), .AW(5), .SLOW_IDX(1), .RA_ADDR(31)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic req(input logic [1:0] sel, input logic [1:0] dsel, input logic [4:0] rd, input logic [4:0] rt, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.data_sel = sel;
        bus.dst_sel  = dsel;
        bus.rd_addr  = rd;
        bus.rt_addr  = rt;
        bus.src_data = '0;
        bus.src_data[sel*32 +: 32] = d;
    endtask
    initial begin
        reset = 1'b0; flush = 1'b0;
        bus.in_valid = 0; bus.data_sel = 0; bus.dst_sel = 0; bus.rd_addr = 0; bus.rt_addr = 0;
        bus.src_data = '0; bus.slow_valid = 0; bus.slow_data = 0; bus.out_ready = 1;
        step(); step();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", bus.wr_data, 0);
        reset = 1'b1;
        #1 chk("rst_in_ready", 32'(bus.in_ready), 1);
        // slow request parked in WAIT, then abandoned by reset
        step();
        req(2'd1, 2'd1, 5'd0, 5'd12, 32'h0);
        step();
        bus.in_valid = 0;
        #1 chk("wait_in_ready", 32'(bus.in_ready), 0);
        reset = 1'b0;
        #1 chk("midwait_rst_out_valid", 32'(bus.out_valid), 0);
        chk("midwait_rst_wr_addr", 32'(bus.wr_addr), 0);
        step();
        reset = 1'b1;
        #1 chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        bus.slow_valid = 1; bus.slow_data = 32'h7777_7777;
        step();
        bus.slow_valid = 0;
        chk("abandoned_out_valid", 32'(bus.out_valid), 0);
        // fast path
        req(2'd0, 2'd0, 5'd5, 5'd0, 32'h1234_5678);
        #1 chk("fast_in_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 0;
        #1 chk("fast_wr_en", 32'(bus.wr_en), 1);
        chk("fast_wr_addr", 32'(bus.wr_addr), 5);
        chk("fast_wr_data", bus.wr_data, 32'h1234_5678);
        step();
        chk("fast_drain", 32'(bus.out_valid), 0);
        // slow path, data three cycles after accept
        req(2'd1, 2'd1, 5'd0, 5'd9, 32'h0);
        step();
        bus.in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("slow_in_ready", 32'(bus.in_ready), 0);
            chk("slow_out_valid", 32'(bus.out_valid), 0);
            if (i == 2) begin bus.slow_valid = 1; bus.slow_data = 32'hDEAD_BEEF; end
            step();
        end
        bus.slow_valid = 0;
        #1 chk("slow_wr_addr", 32'(bus.wr_addr), 9);
        chk("slow_wr_data", bus.wr_data, 32'hDEAD_BEEF);
        chk("slow_wr_en", 32'(bus.wr_en), 1);
        step();
        // slow source already valid at accept
        req(2'd1, 2'd0, 5'd7, 5'd0, 32'h0);
        bus.slow_valid = 1; bus.slow_data = 32'h5151_5151;
        step();
        bus.in_valid = 0; bus.slow_valid = 0;
        chk("slow_now_out_valid", 32'(bus.out_valid), 1);
        chk("slow_now_wr_data", bus.wr_data, 32'h5151_5151);
        chk("slow_now_wr_addr", 32'(bus.wr_addr), 7);
        step();
        // link register
        req(2'd2, 2'd2, 5'd3, 5'd4, 32'hAAAA_0002);
        step();
        bus.in_valid = 0;
        #1 chk("link_wr_addr", 32'(bus.wr_addr), 31);
        chk("link_wr_en", 32'(bus.wr_en), 1);
        chk("link_wr_data", bus.wr_data, 32'hAAAA_0002);
        step();
        // $zero destination
        req(2'd3, 2'd0, 5'd0, 5'd4, 32'h0000_0333);
        step();
        bus.in_valid = 0;
        #1 chk("zero_out_valid", 32'(bus.out_valid), 1);
        chk("zero_wr_en", 32'(bus.wr_en), 0);
        step();
        // dst_sel 3 maps to no destination
        req(2'd0, 2'd3, 5'd8, 5'd9, 32'h0000_0444);
        step();
        bus.in_valid = 0;
        #1 chk("none_wr_addr", 32'(bus.wr_addr), 0);
        chk("none_wr_en", 32'(bus.wr_en), 0);
        step();
        // backpressure: A held two cycles, then B and C back to back
        req(2'd0, 2'd0, 5'd1, 5'd0, 32'hA0A0_A0A0);
        step();
        bus.out_ready = 0;
        req(2'd0, 2'd0, 5'd2, 5'd0, 32'hB0B0_B0B0);
        for (int i = 0; i < 2; i++) begin
            #1 chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_wr_en", 32'(bus.wr_en), 0);
            chk("bp_hold_data", bus.wr_data, 32'hA0A0_A0A0);
            chk("bp_hold_addr", 32'(bus.wr_addr), 1);
            step();
        end
        bus.out_ready = 1;
        #1 chk("bp_a_wr_en", 32'(bus.wr_en), 1);
        chk("bp_a_in_ready", 32'(bus.in_ready), 1);
        chk("bp_a_data", bus.wr_data, 32'hA0A0_A0A0);
        step();
        req(2'd0, 2'd0, 5'd3, 5'd0, 32'hC0C0_C0C0);
        #1 chk("bp_b_data", bus.wr_data, 32'hB0B0_B0B0);
        chk("bp_b_addr", 32'(bus.wr_addr), 2);
        chk("bp_b_wr_en", 32'(bus.wr_en), 1);
        step();
        bus.in_valid = 0;
        #1 chk("bp_c_data", bus.wr_data, 32'hC0C0_C0C0);
        chk("bp_c_addr", 32'(bus.wr_addr), 3);
        chk("bp_c_wr_en", 32'(bus.wr_en), 1);
        step();
        chk("bp_no_dup", 32'(bus.out_valid), 0);
        // flush while FULL with a competing request
        bus.out_ready = 0;
        req(2'd0, 2'd0, 5'd4, 5'd0, 32'hD0D0_D0D0);
        step();
        req(2'd0, 2'd0, 5'd6, 5'd0, 32'hE0E0_E0E0);
        flush = 1; bus.out_ready = 1;
        #1 chk("flush_in_ready", 32'(bus.in_ready), 0);
        chk("flush_wr_en", 32'(bus.wr_en), 0);
        step();
        flush = 0; bus.in_valid = 0;
        #1 chk("flush_out_valid", 32'(bus.out_valid), 0);
        chk("flush_wr_en_after", 32'(bus.wr_en), 0);
        chk("flush_idle_ready", 32'(bus.in_ready), 1);
        step();
        chk("flush_not_accepted", 32'(bus.out_valid), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
